// File: rtl/font_render.sv
// Final pixel stage: resolves each stream word to an RGB colour through an 8x8 glyph ROM.
// Fixed 3-stage pipeline; syncs and display-enable are delay-matched to the pixel colour.

package font_render_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 10;
    localparam int ADDR_W = 8;
    localparam int ZOOM_W = 3;

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           hs;
        logic           vs;
        logic           de;
    } vpart1_t;

    typedef struct packed {
        logic [2:0]        cs;
        logic [ADDR_W-1:0] addr;
        logic              ha;
        logic [ZOOM_W-1:0] zoom;
        rgb_t              bg;
        rgb_t              fg;
    } vpart2_t;

    typedef struct packed {
        vpart1_t vpart1;
        vpart2_t vpart2;
    } stream_t;

    // Default glyph image: each byte equals the low 8 bits of its own address.
    function automatic logic [2047:0][7:0] identity_font();
        logic [2047:0][7:0] img;
        for (int a = 0; a < 2048; a++) begin
            img[a] = 8'(a);
        end
        return img;
    endfunction

endpackage


module font_render
    import font_render_pkg::*;
#(
    parameter logic [7:0]         ASCII_BASE = 8'h20,
    parameter logic [2:0]         CS_FONT    = 3'd0,
    parameter logic               SYNC_ACT   = 1'b0,
    parameter logic [2047:0][7:0] FONT_IMAGE = identity_font()
) (
    input  logic    px_clk,
    input  logic    rst_n,
    input  logic    en,
    input  stream_t in,
    output rgb_t    rgb,
    output logic    hsync,
    output logic    vsync,
    output logic    de
);

    // ---------------- S1: glyph addressing ----------------
    logic [7:0]  code;
    logic [2:0]  row;
    logic [2:0]  col;

    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
        code = in.vpart2.addr;
        if (in.vpart2.ha) begin
            code = in.vpart2.addr - ASCII_BASE;
        end
        row = 3'(in.vpart1.y >> in.vpart2.zoom);
        col = 3'(in.vpart1.x >> in.vpart2.zoom);
    end

    logic [10:0] rom_addr_s1;
    logic [2:0]  col_s1;
    rgb_t        fg_s1;
    rgb_t        bg_s1;
    logic [2:0]  cs_s1;
    logic        de_s1;
    logic        en_s1;
    logic        hs_s1;
    logic        vs_s1;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
            rom_addr_s1 <= '0;
            col_s1      <= '0;
            fg_s1       <= '0;
            bg_s1       <= '0;
            cs_s1       <= '0;
            de_s1       <= 1'b0;
            en_s1       <= 1'b0;
            hs_s1       <= ~SYNC_ACT;
            vs_s1       <= ~SYNC_ACT;
        end else begin
            rom_addr_s1 <= {code, row};
            col_s1      <= col;
            fg_s1       <= in.vpart2.fg;
            bg_s1       <= in.vpart2.bg;
            cs_s1       <= in.vpart2.cs;
            de_s1       <= in.vpart1.de;
            en_s1       <= en;
            hs_s1       <= in.vpart1.hs;
            vs_s1       <= in.vpart1.vs;
        end
    end

    // ---------------- S2: synchronous ROM read ----------------
    logic [7:0] glyph_s2;

    // NOTE: the ROM output register has no reset; its value is ignored until de reaches S3.
    always_ff @(posedge px_clk) begin
        glyph_s2 <= FONT_IMAGE[rom_addr_s1];
    end

    logic [2:0] col_s2;
    rgb_t       fg_s2;
    rgb_t       bg_s2;
    logic [2:0] cs_s2;
    logic       de_s2;
    logic       en_s2;
    logic       hs_s2;
    logic       vs_s2;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s2 <= '0;
            fg_s2  <= '0;
            bg_s2  <= '0;
            cs_s2  <= '0;
            de_s2  <= 1'b0;
            en_s2  <= 1'b0;
            hs_s2  <= ~SYNC_ACT;
            vs_s2  <= ~SYNC_ACT;
        end else begin
            col_s2 <= col_s1;
            fg_s2  <= fg_s1;
            bg_s2  <= bg_s1;
            cs_s2  <= cs_s1;
            de_s2  <= de_s1;
            en_s2  <= en_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    // ---------------- S3: pixel select and output register ----------------
    logic pix;
    rgb_t rgb_next;

    always_comb begin
        // MSB of the glyph byte is the leftmost pixel.
        pix      = glyph_s2[3'd7 - col_s2];
        rgb_next = '0;
        if (en_s2 && de_s2) begin
            if (cs_s2 != CS_FONT) begin
                rgb_next = bg_s2;
            end else if (pix) begin
                rgb_next = fg_s2;
            end else begin
                rgb_next = bg_s2;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= ~SYNC_ACT;
            vsync <= ~SYNC_ACT;
        end else begin
            rgb   <= rgb_next;
            de    <= de_s2;
            hsync <= hs_s2;
            vsync <= vs_s2;
        end
    end

endmodule

// File: tb/tb_font_render.sv
// Self-checking bench for font_render: a 3-deep behavioural model checked every cycle,
// plus literal expectations for the directed glyph, zoom, blanking, reset and sync cases.

module tb_font_render;
    import font_render_pkg::*;

    localparam rgb_t BLACK = 3'b000;
    localparam rgb_t BLUE  = 3'b001;
    localparam rgb_t RED   = 3'b100;
    localparam rgb_t WHITE = 3'b111;

    typedef struct packed {
        rgb_t rgb;
        logic hs;
        logic vs;
        logic de;
    } exp_t;

    logic    px_clk = 1'b0;
    logic    rst_n  = 1'b0;
    logic    en_w   = 1'b1;
    stream_t in_w   = '0;
    rgb_t    rgb;
    logic    hsync;
    logic    vsync;
    logic    de;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    exp_t pipe [3];
    int   hs_falls[$];
    int   vs_falls[$];
    logic prev_in_hs = 1'b1;
    logic prev_in_vs = 1'b1;
    logic prev_hsync = 1'b1;
    logic prev_vsync = 1'b1;

    font_render dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .en     (en_w),
        .in     (in_w),
        .rgb    (rgb),
        .hsync  (hsync),
        .vsync  (vsync),
        .de     (de)
    );

    always #5 px_clk = ~px_clk;

    always @(posedge px_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural model: derives the colour from the rendering rules and the bench font
    // (byte at ROM address a equals a mod 256).
    function automatic exp_t model(input stream_t p, input logic e);
        exp_t r;
        int   code, row, col, g, pix;
        r.hs  = p.vpart1.hs;
        r.vs  = p.vpart1.vs;
        r.de  = p.vpart1.de;
        r.rgb = BLACK;
        code  = p.vpart2.ha ? (int'(p.vpart2.addr) - 32 + 256) % 256 : int'(p.vpart2.addr);
        row   = (int'(p.vpart1.y) >> p.vpart2.zoom) % 8;
        col   = (int'(p.vpart1.x) >> p.vpart2.zoom) % 8;
        g     = (code * 8 + row) % 256;
        pix   = (g >> (7 - col)) % 2;
        if (e && p.vpart1.de) begin
            if (p.vpart2.cs != 3'd0) r.rgb = p.vpart2.bg;
            else                     r.rgb = (pix != 0) ? p.vpart2.fg : p.vpart2.bg;
        end
        return r;
    endfunction

    function automatic exp_t reset_exp();
        exp_t r;
        r.rgb = BLACK;
        r.hs  = 1'b1;
        r.vs  = 1'b1;
        r.de  = 1'b0;
        return r;
    endfunction

    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = reset_exp();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = model(in_w, en_w);
        end
    end

    always @(negedge px_clk) begin
        if (cmp_en) begin
            check("rgb",   32'(rgb),   32'(pipe[2].rgb));
            check("hsync", 32'(hsync), 32'(pipe[2].hs));
            check("vsync", 32'(vsync), 32'(pipe[2].vs));
            check("de",    32'(de),    32'(pipe[2].de));
            if (prev_hsync === 1'b1 && hsync === 1'b0) begin
                if (hs_falls.size() == 0) check("hsync_fall_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else check("hsync_fall_latency", 32'(cyc - hs_falls.pop_front()), 32'd3);
            end
            if (prev_vsync === 1'b1 && vsync === 1'b0) begin
                if (vs_falls.size() == 0) check("vsync_fall_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else check("vsync_fall_latency", 32'(cyc - vs_falls.pop_front()), 32'd3);
            end
            prev_hsync = hsync;
            prev_vsync = vsync;
        end
    end

    function automatic stream_t mk_px(input int x, input int y, input int addr, input bit ha,
                                      input int zoom, input rgb_t fg, input rgb_t bg,
                                      input int cs, input bit pde);
        stream_t p;
        p             = '0;
        p.vpart1.x    = X_W'(x);
        p.vpart1.y    = Y_W'(y);
        p.vpart1.hs   = 1'b1;
        p.vpart1.vs   = 1'b1;
        p.vpart1.de   = pde;
        p.vpart2.cs   = 3'(cs);
        p.vpart2.addr = ADDR_W'(addr);
        p.vpart2.ha   = ha;
        p.vpart2.zoom = ZOOM_W'(zoom);
        p.vpart2.fg   = fg;
        p.vpart2.bg   = bg;
        return p;
    endfunction

    task automatic drive(input stream_t p, input logic e);
        @(negedge px_clk);
        in_w = p;
        en_w = e;
        if (prev_in_hs && !p.vpart1.hs) hs_falls.push_back(cyc);
        if (prev_in_vs && !p.vpart1.vs) vs_falls.push_back(cyc);
        prev_in_hs = p.vpart1.hs;
        prev_in_vs = p.vpart1.vs;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        stream_t p;
        int      t0;

        // Literal pins on the model itself.
        check("pin_glyph_x4",   32'(model(mk_px(4, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(WHITE));
        check("pin_glyph_x3",   32'(model(mk_px(3, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(BLUE));
        check("pin_xlate_x6",   32'(model(mk_px(6, 3, 8'h21, 1, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(WHITE));
        check("pin_xlate_x5",   32'(model(mk_px(5, 3, 8'h21, 1, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(BLUE));
        check("pin_wrap_x0",    32'(model(mk_px(0, 0, 8'h10, 1, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(WHITE));
        check("pin_wrap_x1",    32'(model(mk_px(1, 0, 8'h10, 1, 0, WHITE, BLUE, 0, 1), 1).rgb), 32'(BLUE));
        check("pin_zoom2_x16",  32'(model(mk_px(16, 0, 8'h01, 0, 2, WHITE, BLUE, 0, 1), 1).rgb), 32'(WHITE));
        check("pin_zoom2_x15",  32'(model(mk_px(15, 0, 8'h01, 0, 2, WHITE, BLUE, 0, 1), 1).rgb), 32'(BLUE));

        // Initial reset.
        in_w = mk_px(0, 0, 0, 0, 0, BLACK, BLACK, 0, 0);
        repeat (2) @(negedge px_clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge px_clk);
        #2 rst_n = 1'b1;

        // Glyph: code 0x01, row 0 -> 0x08, only x=4 is foreground.
        for (int x = 0; x < 8; x++) drive(mk_px(x, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 1), 1'b1);

        // Translate: 0x21 - 0x20 = 0x01, row 3 -> 0x0B; then 0x10 wraps to 0xF0.
        for (int x = 0; x < 8; x++) drive(mk_px(x, 3, 8'h21, 1, 0, WHITE, BLUE, 0, 1), 1'b1);
        for (int x = 0; x < 8; x++) drive(mk_px(x, 0, 8'h10, 1, 0, WHITE, BLUE, 0, 1), 1'b1);

        // Zoom 1 and 2, plus an oversized zoom that still shifts.
        for (int x = 0; x < 16; x++) drive(mk_px(x, 0, 8'h01, 0, 1, WHITE, BLUE, 0, 1), 1'b1);
        for (int x = 0; x < 32; x++) drive(mk_px(x, 0, 8'h01, 0, 2, WHITE, BLUE, 0, 1), 1'b1);
        for (int x = 0; x < 8; x++) drive(mk_px(x * 128, 5, 8'h41, 0, 7, RED, BLUE, 0, 1), 1'b1);

        // Blanking / select / unclaimed pixels.
        for (int x = 0; x < 8; x++) drive(mk_px(x, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 0), 1'b1);
        for (int x = 0; x < 8; x++) begin
            p = mk_px(x, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 1);
            p.vpart1.hs = (x < 2 || x > 4);
            drive(p, 1'b0);
        end
        for (int x = 0; x < 8; x++) drive(mk_px(x, 0, 8'h01, 0, 0, WHITE, RED, 1, 1), 1'b1);
        for (int x = 0; x < 4; x++) begin
            p = mk_px(x + 4, 0, 0, 0, 0, BLACK, BLACK, 0, 1);
            p.vpart2 = '0;
            drive(p, 1'b1);
        end

        // Mid-stream reset held 5 clocks, released with a foreground pixel presented.
        for (int i = 0; i < 3; i++) drive(mk_px(4, 0, 8'h01, 0, 0, WHITE, BLUE, 0, 1), 1'b1);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge px_clk);
            check("reset_rgb",   32'(rgb),   32'd0);
            check("reset_de",    32'(de),    32'd0);
            check("reset_hsync", 32'(hsync), 32'd1);
            check("reset_vsync", 32'(vsync), 32'd1);
        end
        #2 rst_n = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            @(negedge px_clk);
            if (k < 3) begin
                check("no_early_de", 32'(de), 32'd0);
            end else begin
                check("first_out_cycle", 32'(cyc - t0), 32'd3);
                check("first_out_de",    32'(de),       32'd1);
                check("first_out_rgb",   32'(rgb),      32'(WHITE));
            end
        end

        // Sync alignment over a small frame: 40 clocks per line, 12 lines.
        for (int v = 0; v < 12; v++) begin
            for (int h = 0; h < 40; h++) begin
                p = mk_px(h, v, (h * 3 + v) % 256, (h % 5) == 0, h % 3, rgb_t'(h % 8), rgb_t'(v % 8),
                          (v == 7) ? 2 : 0, (h < 32) && (v < 8));
                p.vpart1.hs = !(h >= 30 && h < 34);
                p.vpart1.vs = !(v >= 10);
                drive(p, 1'b1);
            end
        end
        for (int i = 0; i < 5; i++) drive(mk_px(0, 0, 0, 0, 0, BLACK, BLACK, 0, 0), 1'b1);

        check("hsync_falls_pending", 32'(hs_falls.size()), 32'd0);
        check("vsync_falls_pending", 32'(vs_falls.size()), 32'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
